prefetch_queue: RTL and testbench
=================================

# prefetch_queue

Parametrised instruction prefetcher with an integrated byte queue. It fetches aligned words of `BUS_BYTES` bytes from CS:IP over a single-outstanding memory port. It unpacks every valid byte lane into an internal `DEPTH`-byte queue in one cycle and presents the byte stream, each byte tagged with its IP, to the decoder. It sits between the bus interface unit and the instruction decoder, and flushes and redirects on `load_new_ip`.

## Interface
- `BUS_BYTES`, default 2: memory data width in bytes; 2 or 4.
- `DEPTH`, default 8: queue capacity in bytes; power of two, >= 2*`BUS_BYTES`.
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `cs`  in  16  code segment.
- `new_ip`  in  16  redirect target IP.
- `load_new_ip`  in  1  flush the queue and redirect fetching to `new_ip`.
- `rd_en`  in  1  consume the head byte.
- `rd_valid`  out  1  queue non-empty.
- `rd_data`  out  8  head byte.
- `rd_ip`  out  16  IP of the head byte.
- `level`  out  clog2(DEPTH)+1  bytes currently queued.
- `mem_access`  out  1  memory request.
- `mem_ack`  in  1  request complete; `mem_data` valid this cycle.
- `mem_address`  out  20  physical, word-aligned address.
- `mem_data`  in  8*BUS_BYTES  read data; lane k holds byte address+k.
- `halt`  in  1  inhibit new fetches. Present only with `PREFETCH_HALT_EN`.

## Operation
- Registers:
  - `fetch_ip`: IP of the next byte to request.
  - `head_ip`: drives `rd_ip`.
  - Queue RAM with read and write pointers.
  - `level`.
  - 2-bit state: IDLE, FETCH, ABORT.
- `mem_access` = (state != IDLE).
- `mem_address` = {cs,4'b0} + {4'b0, fetch_ip with low log2(BUS_BYTES) bits cleared}, computed modulo 2^20.
- State transitions:
  - IDLE -> FETCH when `DEPTH - level >= BUS_BYTES`, `!load_new_ip` and `!halt`.
  - FETCH -> IDLE on `mem_ack`.
  - FETCH -> ABORT on `load_new_ip` without `mem_ack`.
  - ABORT -> IDLE on `mem_ack`.
  - An ABORT request is held until acked because the bus cannot withdraw it; its data is discarded.
- Ack in FETCH (and not `load_new_ip`):
  - off = fetch_ip mod BUS_BYTES.
  - Lanes off..BUS_BYTES-1 are written in ascending order, so n = BUS_BYTES-off bytes.
  - `fetch_ip` += n, modulo 2^16. The IP wraps inside the segment; the physical address is not carried.
- Read: `rd_en && rd_valid` pops the head and increments `head_ip` (mod 2^16). `rd_en` while empty is ignored.
- Same-cycle write and read: `level` += n - 1. No overflow is possible, because space is checked before issue and only one request is outstanding.
- `load_new_ip` takes priority over everything:
  - Sets level to 0 and clears both pointers.
  - Sets `fetch_ip` and `head_ip` to `new_ip`.
  - Ignores `rd_en`.
  - Discards any same-cycle ack data.
- `mem_ack` while IDLE is ignored. This covers a stale ack after a reset.

## Timing
- Reset values:
  - `mem_access` 0
  - `rd_valid` 0
  - `level` 0
  - `rd_ip` 0x0000
  - `rd_data` don't-care
  - `mem_address` {cs,4'b0}
  - State IDLE, `fetch_ip` 0.
- Reset asserted mid-FETCH drops `mem_access` on the next cycle. The external bus must tolerate this; any late ack is ignored.
- Redirect latency, with `load_new_ip` at cycle T:
  - Queue is empty at T+1.
  - `mem_access` first rises at T+2, or after the ABORT ack if an ABORT was pending.
- Ack to output: bytes written on ack cycle A are visible on `rd_valid`/`rd_data` at A+1.
- `mem_access` is low for at least one cycle after each ack, because IDLE is re-entered.
- With zero-wait memory (ack one cycle after `mem_access` rises), sustained throughput is BUS_BYTES bytes per 2 cycles.

## Configuration
- `PREFETCH_HALT_EN` defined:
  - Adds the `halt` input. While it is high, IDLE does not issue.
  - An in-flight FETCH or ABORT completes normally.
  - Queue reads continue.
- `PREFETCH_HALT_EN` undefined: the port is absent and the block behaves as `halt`=0.

## Test plan
- Odd start: BUS_BYTES=2, DEPTH=8, cs=0x1000, load `new_ip`=0x0003.
  - `mem_address`=0x10002. Ack with 0xAABB queues only 0xAA, with `rd_ip`=0x0003.
  - Next `mem_address`=0x10004.
- Full and space:
  - No reads, zero-wait memory: `level` reaches 8 and `mem_access` stays 0.
  - One pop gives `level` 7 and still no fetch.
  - A second pop gives `level` 6, and `mem_access` rises the next cycle.
  - A pop on the ack cycle gives `level` += 1.
- Abort: `load_new_ip` 0x0100 while FETCH is pending, then ack with 0x1234 two cycles later.
  - `rd_valid` stays 0.
  - The next request is at cs*16+0x100, issued the cycle after the ack.
- Segment wrap: cs=0xF000, ip=0xFFFF.
  - `mem_address`=0xFFFFE and lane 1 is queued.
  - Next `mem_address`=0xF0000 and the next byte has `rd_ip`=0x0000.
- 20-bit wrap: cs=0xFFFF, ip=0x0010 gives `mem_address`=0x00000.
  - Reset during FETCH, then ack: `mem_access`=0 and `level`=0.
- Halt (`PREFETCH_HALT_EN`): halt=1 with an empty queue gives no `mem_access` for 10 cycles.
  - Releasing halt gives `mem_access` on the next cycle.
  - Halt during FETCH still queues the acked bytes.

Source files
------------

// File: rtl/prefetch_queue.sv
// Instruction prefetcher: fetches aligned BUS_BYTES-wide words from CS:IP and queues the bytes, each tagged with its IP.
// Optional `halt` input (blocks new fetches) is compiled in when PREFETCH_HALT_EN is defined.
module prefetch_queue #(
  parameter int BUS_BYTES = 2,
  parameter int DEPTH     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [15:0]              cs,
  input  logic [15:0]              new_ip,
  input  logic                     load_new_ip,
  input  logic                     rd_en,
  output logic                     rd_valid,
  output logic [7:0]               rd_data,
  output logic [15:0]              rd_ip,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     mem_access,
  input  logic                     mem_ack,
  output logic [19:0]              mem_address,
  input  logic [8*BUS_BYTES-1:0]   mem_data
`ifdef PREFETCH_HALT_EN
  ,
  input  logic                     halt
`endif
);

  localparam int OFF_W = $clog2(BUS_BYTES);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] ABORT = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [15:0]      fetch_ip;
  logic [15:0]      head_ip;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [7:0]       ram [DEPTH];

  logic             halt_i;
  logic             can_issue;
  logic             wr_fire;
  logic             pop;
  logic [OFF_W-1:0] off;
  logic [LVL_W-1:0] n_bytes;
  logic [LVL_W-1:0] space;

`ifdef PREFETCH_HALT_EN
  assign halt_i = halt;
`else
  assign halt_i = 1'b0;
`endif

  // Read handshake: a byte transfers on every cycle where rd_valid && rd_en, unless
  // load_new_ip is high in that cycle (the flush wins). rd_en while empty is ignored.
  assign rd_valid = (level != '0);
  assign rd_data  = ram[rd_ptr];
  assign rd_ip    = head_ip;
  assign pop      = rd_en && rd_valid && !load_new_ip;

  assign mem_access  = (state != IDLE);
  assign mem_address = {cs, 4'b0000} + {4'b0000, fetch_ip[15:OFF_W], {OFF_W{1'b0}}};

  // A word fetched from an odd offset only contributes its upper lanes.
  assign off       = fetch_ip[OFF_W-1:0];
  assign n_bytes   = LVL_W'(BUS_BYTES) - LVL_W'(off);
  assign space     = LVL_W'(DEPTH) - level;
  assign can_issue = (space >= LVL_W'(BUS_BYTES)) && !load_new_ip && !halt_i;
  assign wr_fire   = (state == FETCH) && mem_ack && !load_new_ip;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (can_issue) state_nxt = FETCH;
      FETCH: begin
        if (mem_ack)          state_nxt = IDLE;
        else if (load_new_ip) state_nxt = ABORT;
      end
      // The bus cannot withdraw a request, so a redirected fetch waits for its ack.
      ABORT:   if (mem_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      fetch_ip <= 16'h0000;
      head_ip  <= 16'h0000;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
    end else begin
      state <= state_nxt;
      if (load_new_ip) begin
        fetch_ip <= new_ip;
        head_ip  <= new_ip;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        level    <= '0;
      end else begin
        if (wr_fire) begin
          fetch_ip <= fetch_ip + 16'(n_bytes);
          wr_ptr   <= wr_ptr + PTR_W'(n_bytes);
        end
        if (pop) begin
          rd_ptr  <= rd_ptr + PTR_W'(1);
          head_ip <= head_ip + 16'd1;
        end
        level <= level + (wr_fire ? n_bytes : LVL_W'(0)) - LVL_W'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire && !reset) begin
      for (int k = 0; k < BUS_BYTES; k++) begin
        if (k >= int'(off)) ram[wr_ptr + PTR_W'(k - int'(off))] <= mem_data[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_prefetch_queue.sv
// Self-checking bench for prefetch_queue: directed scenarios plus random traffic against a byte-queue reference model.
// Halt scenarios are included when PREFETCH_HALT_EN is defined.
module tb_prefetch_queue;

  localparam int BB  = 2;
  localparam int DEP = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [15:0]     cs;
  logic [15:0]     new_ip;
  logic            load_new_ip;
  logic            rd_en;
  logic            rd_valid;
  logic [7:0]      rd_data;
  logic [15:0]     rd_ip;
  logic [3:0]      level;
  logic            mem_access;
  logic            mem_ack;
  logic [19:0]     mem_address;
  logic [8*BB-1:0] mem_data;
  logic            halt;

  int total = 0;
  int bad   = 0;
  int lat   = 0;
  bit chk_en = 1'b0;

  // Reference model: queued bytes as {ip, byte}, next fetch IP, outstanding / stale request.
  logic [23:0] exp_q[$];
  logic [15:0] m_fip   = 16'h0000;
  logic        m_busy  = 1'b0;
  logic        m_stale = 1'b0;

  prefetch_queue #(.BUS_BYTES(BB), .DEPTH(DEP)) dut (
    .clk(clk), .reset(reset), .cs(cs), .new_ip(new_ip), .load_new_ip(load_new_ip),
    .rd_en(rd_en), .rd_valid(rd_valid), .rd_data(rd_data), .rd_ip(rd_ip), .level(level),
    .mem_access(mem_access), .mem_ack(mem_ack), .mem_address(mem_address), .mem_data(mem_data)
`ifdef PREFETCH_HALT_EN
    , .halt(halt)
`endif
  );

  always #5 clk = ~clk;

  // One clock cycle: compare against the model mid-cycle, advance the model, then step past the edge.
  task automatic tick();
    int sz;
    int off;
    logic [19:0] ea;
    @(negedge clk);
    sz = exp_q.size();
    if (chk_en) begin
      ea = 20'((int'(cs) * 16 + int'(m_fip) - int'(m_fip) % BB) % (1 << 20));
      total++; if (mem_access !== m_busy) begin bad++; $display("FAIL mem_access: got %b want %b", mem_access, m_busy); end
      total++; if (mem_address !== ea) begin bad++; $display("FAIL mem_address: got %h want %h", mem_address, ea); end
      total++; if (rd_valid !== (sz != 0)) begin bad++; $display("FAIL rd_valid: got %b want %b", rd_valid, sz != 0); end
      total++; if (level !== 4'(sz)) begin bad++; $display("FAIL level: got %0d want %0d", level, sz); end
      if (sz != 0) begin
        total++;
        if ({rd_ip, rd_data} !== exp_q[0]) begin
          bad++; $display("FAIL head: got ip=%h data=%h want ip=%h data=%h", rd_ip, rd_data, exp_q[0][23:8], exp_q[0][7:0]);
        end
      end
    end
    if (reset) begin
      exp_q.delete(); m_fip = 16'h0000; m_busy = 1'b0; m_stale = 1'b0;
    end else if (load_new_ip) begin
      exp_q.delete(); m_fip = new_ip;
      if (m_busy && !mem_ack) m_stale = 1'b1;
      else begin m_busy = 1'b0; m_stale = 1'b0; end
    end else begin
      if (rd_en && sz != 0) void'(exp_q.pop_front());
      if (m_busy) begin
        if (mem_ack) begin
          if (!m_stale) begin
            off = int'(m_fip) % BB;
            for (int k = off; k < BB; k++) exp_q.push_back({m_fip + 16'(k - off), mem_data[8*k +: 8]});
            m_fip = m_fip + 16'(BB - off);
          end
          m_busy = 1'b0; m_stale = 1'b0;
        end
      end else if ((DEP - sz >= BB) && !halt) begin
        m_busy = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Memory responder: acks a pending request after 0..max_lat extra cycles.
  task automatic mem_resp(input int max_lat, input bit spurious);
    mem_data = (8*BB)'($urandom);
    if (mem_access) begin
      if (lat == 0) begin mem_ack = 1'b1; lat = $urandom_range(max_lat, 0); end
      else begin mem_ack = 1'b0; lat--; end
    end else begin
      mem_ack = spurious && ($urandom_range(7, 0) == 0);
    end
  endtask

  // Reset, then redirect to c:ip; returns one cycle after the redirect with the queue empty.
  task automatic restart(input logic [15:0] c, input logic [15:0] ip);
    reset = 1'b1; load_new_ip = 1'b0; mem_ack = 1'b0; rd_en = 1'b0; tick();
    reset = 1'b0; cs = c; new_ip = ip; load_new_ip = 1'b1; tick();
    load_new_ip = 1'b0;
  endtask

  task automatic test_reset();
    cs = 16'h1234; reset = 1'b1;
    tick(); tick();
    chk_en = 1'b1;
    total++; if (mem_access !== 1'b0) begin bad++; $display("FAIL rst_mem_access: got %b want 0", mem_access); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL rst_rd_valid: got %b want 0", rd_valid); end
    total++; if (level !== 4'd0) begin bad++; $display("FAIL rst_level: got %0d want 0", level); end
    total++; if (rd_ip !== 16'h0000) begin bad++; $display("FAIL rst_rd_ip: got %h want 0000", rd_ip); end
    total++; if (mem_address !== 20'h12340) begin bad++; $display("FAIL rst_mem_address: got %h want 12340", mem_address); end
    tick();
  endtask

  task automatic test_odd_start();
    restart(16'h1000, 16'h0003);
    total++; if (mem_access !== 1'b0) begin bad++; $display("FAIL odd_t1_access: got %b want 0", mem_access); end
    tick();
    total++; if (mem_access !== 1'b1) begin bad++; $display("FAIL odd_t2_access: got %b want 1", mem_access); end
    total++; if (mem_address !== 20'h10002) begin bad++; $display("FAIL odd_addr: got %h want 10002", mem_address); end
    mem_ack = 1'b1; mem_data = 16'hAABB; tick(); mem_ack = 1'b0;
    total++; if (rd_data !== 8'hAA) begin bad++; $display("FAIL odd_data: got %h want aa", rd_data); end
    total++; if (rd_ip !== 16'h0003) begin bad++; $display("FAIL odd_ip: got %h want 0003", rd_ip); end
    total++; if (level !== 4'd1) begin bad++; $display("FAIL odd_level: got %0d want 1", level); end
    tick();
    total++; if (mem_address !== 20'h10004) begin bad++; $display("FAIL odd_next_addr: got %h want 10004", mem_address); end
    mem_ack = 1'b1; mem_data = 16'h5566; tick(); mem_ack = 1'b0;
    total++; if (level !== 4'd3) begin bad++; $display("FAIL odd_level2: got %0d want 3", level); end
  endtask

  task automatic test_full_space();
    restart(16'h1000, 16'h0000);
    repeat (20) begin mem_resp(0, 1'b0); tick(); end
    mem_ack = 1'b0; tick();
    total++; if (level !== 4'd8) begin bad++; $display("FAIL full_level: got %0d want 8", level); end
    total++; if (mem_access !== 1'b0) begin bad++; $display("FAIL full_access: got %b want 0", mem_access); end
    rd_en = 1'b1; tick(); rd_en = 1'b0; tick();
    total++; if (level !== 4'd7) begin bad++; $display("FAIL pop1_level: got %0d want 7", level); end
    total++; if (mem_access !== 1'b0) begin bad++; $display("FAIL pop1_access: got %b want 0", mem_access); end
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    total++; if (level !== 4'd6) begin bad++; $display("FAIL pop2_level: got %0d want 6", level); end
    tick();
    total++; if (mem_access !== 1'b1) begin bad++; $display("FAIL pop2_access: got %b want 1", mem_access); end
    mem_ack = 1'b1; mem_data = 16'h0F1E; rd_en = 1'b1; tick(); mem_ack = 1'b0; rd_en = 1'b0;
    total++; if (level !== 4'd7) begin bad++; $display("FAIL ack_pop_level: got %0d want 7", level); end
  endtask

  task automatic test_abort();
    restart(16'h1000, 16'h0040); tick();
    total++; if (mem_access !== 1'b1) begin bad++; $display("FAIL abort_pre_access: got %b want 1", mem_access); end
    new_ip = 16'h0100; load_new_ip = 1'b1; tick(); load_new_ip = 1'b0;
    total++; if (mem_access !== 1'b1) begin bad++; $display("FAIL abort_hold: got %b want 1", mem_access); end
    tick();
    mem_ack = 1'b1; mem_data = 16'h1234; tick(); mem_ack = 1'b0;
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL abort_rd_valid: got %b want 0", rd_valid); end
    tick();
    total++; if (mem_access !== 1'b1) begin bad++; $display("FAIL abort_reissue: got %b want 1", mem_access); end
    total++; if (mem_address !== 20'h10100) begin bad++; $display("FAIL abort_addr: got %h want 10100", mem_address); end
    mem_ack = 1'b1; mem_data = 16'hCDEF; tick(); mem_ack = 1'b0;
    total++; if (rd_data !== 8'hEF) begin bad++; $display("FAIL abort_data: got %h want ef", rd_data); end
  endtask

  task automatic test_seg_wrap();
    restart(16'hF000, 16'hFFFF); tick();
    total++; if (mem_address !== 20'hFFFFE) begin bad++; $display("FAIL segw_addr: got %h want ffffe", mem_address); end
    mem_ack = 1'b1; mem_data = 16'h9988; tick(); mem_ack = 1'b0;
    total++; if (rd_data !== 8'h99) begin bad++; $display("FAIL segw_data: got %h want 99", rd_data); end
    total++; if (rd_ip !== 16'hFFFF) begin bad++; $display("FAIL segw_ip: got %h want ffff", rd_ip); end
    tick();
    total++; if (mem_address !== 20'hF0000) begin bad++; $display("FAIL segw_next_addr: got %h want f0000", mem_address); end
    mem_ack = 1'b1; mem_data = 16'h7766; tick(); mem_ack = 1'b0;
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    total++; if (rd_ip !== 16'h0000) begin bad++; $display("FAIL segw_ip2: got %h want 0000", rd_ip); end
    total++; if (rd_data !== 8'h66) begin bad++; $display("FAIL segw_data2: got %h want 66", rd_data); end
  endtask

  task automatic test_wrap20_reset();
    restart(16'hFFFF, 16'h0010); tick();
    total++; if (mem_address !== 20'h00000) begin bad++; $display("FAIL w20_addr: got %h want 00000", mem_address); end
    reset = 1'b1; tick(); reset = 1'b0;
    total++; if (mem_access !== 1'b0) begin bad++; $display("FAIL w20_rst_access: got %b want 0", mem_access); end
    mem_ack = 1'b1; mem_data = 16'h4321; tick(); mem_ack = 1'b0;
    total++; if (level !== 4'd0) begin bad++; $display("FAIL w20_stale_level: got %0d want 0", level); end
  endtask

  task automatic test_back_to_back();
    int acks;
    restart(16'h2000, 16'h0000); tick();
    rd_en = 1'b1; acks = 0; lat = 0;
    repeat (40) begin mem_resp(0, 1'b0); if (mem_ack) acks++; tick(); end
    mem_ack = 1'b0; rd_en = 1'b0;
    total++; if (acks != 20) begin bad++; $display("FAIL b2b_acks: got %0d want 20", acks); end
  endtask

`ifdef PREFETCH_HALT_EN
  task automatic test_halt();
    halt = 1'b1;
    restart(16'h3000, 16'h0000);
    repeat (10) begin
      tick();
      total++; if (mem_access !== 1'b0) begin bad++; $display("FAIL halt_idle: got %b want 0", mem_access); end
    end
    halt = 1'b0; tick();
    total++; if (mem_access !== 1'b1) begin bad++; $display("FAIL halt_release: got %b want 1", mem_access); end
    halt = 1'b1; mem_ack = 1'b1; mem_data = 16'hBEEF; tick(); mem_ack = 1'b0;
    total++; if (level !== 4'd2) begin bad++; $display("FAIL halt_inflight_level: got %0d want 2", level); end
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    total++; if (rd_data !== 8'hBE) begin bad++; $display("FAIL halt_read: got %h want be", rd_data); end
    total++; if (mem_access !== 1'b0) begin bad++; $display("FAIL halt_hold: got %b want 0", mem_access); end
    halt = 1'b0;
  endtask
`endif

  task automatic test_random();
    restart(16'($urandom), 16'($urandom));
    lat = 0;
    repeat (3000) begin
      reset = ($urandom_range(299, 0) == 0);
      load_new_ip = ($urandom_range(39, 0) == 0);
      if (load_new_ip) begin new_ip = 16'($urandom); cs = 16'($urandom); end
      rd_en = ($urandom_range(3, 0) != 0);
`ifdef PREFETCH_HALT_EN
      halt = ($urandom_range(7, 0) == 0);
`endif
      mem_resp(3, 1'b1);
      tick();
    end
    reset = 1'b0; load_new_ip = 1'b0; rd_en = 1'b0; mem_ack = 1'b0; halt = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cs = 16'h0000; new_ip = 16'h0000; load_new_ip = 1'b0;
    rd_en = 1'b0; mem_ack = 1'b0; mem_data = '0; halt = 1'b0;
    test_reset();
    test_odd_start();
    test_full_space();
    test_abort();
    test_seg_wrap();
    test_wrap20_reset();
    test_back_to_back();
`ifdef PREFETCH_HALT_EN
    test_halt();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
